// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: sequential instruction fetch sequencer. Issues word-aligned
// fetches to a fixed-latency memory port and buffers returned words in a
// prefetch FIFO. Decode takes them over a valid/ready handshake. Redirects
// flush both the in-flight fetches and the buffered words.
// Optional build macro: IFETCH_TRACE_EN adds a simulation-only $display trace
// of accepted instructions and redirects.
module ifetch_ctrl #(
   parameter logic [31:0] START_ADDR  = 32'h80020000,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   input  logic        halt,
   output logic        misalign_err
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LAST  = MEM_LATENCY - 1;
   localparam int unsigned PC_W  = MEM_LATENCY * 32;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   state_t                        state_q, state_d;
   logic [31:0]                   fetch_pc;
   logic                          epoch;
   logic [MEM_LATENCY-1:0]        pipe_vld;
   logic [MEM_LATENCY-1:0]        pipe_ep;
   logic [MEM_LATENCY-1:0][31:0]  pipe_pc;
   logic [31:0]                   fifo_pc   [FIFO_DEPTH];
   logic [31:0]                   fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]              rd_ptr, wr_ptr;
   logic [CNT_W-1:0]              fifo_count;
   logic                          redir, pop, push;
   int unsigned                   occupancy;

   // Next state, fetch issue decision and FIFO push/pop qualification
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      redir      = redirect_valid && (state_q != IDLE);
      inst_valid = (fifo_count != '0);
      pop        = inst_valid && inst_ready && !redir;
      push       = pipe_vld[LAST] && (pipe_ep[LAST] == epoch) && !redir;
      // Crediting this cycle's pop lets a full pipeline sustain one fetch per cycle.
      occupancy  = 32'(fifo_count) + 32'($countones(pipe_vld)) - 32'(pop);
      case (state_q)
         IDLE:    state_d = RUN;
         RUN: begin
            if (halt) state_d = HALTED;
            mem_req = !halt && !redirect_valid && (occupancy < FIFO_DEPTH);
         end
         HALTED:  if (!halt) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // Control state, fetch PC, epoch and sticky misalignment flag
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_pc     <= START_ADDR;
         epoch        <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state_q <= state_d;
         if (redir) begin
            fetch_pc <= {redirect_addr[31:2], 2'b00};
            epoch    <= ~epoch;
            if (redirect_addr[1:0] != 2'b00) misalign_err <= 1'b1;
         end else if (mem_req) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
      end
   end

   // In-flight valid shift register; a redirect also drops outstanding
   // valids so the one-bit epoch cannot alias across back-to-back redirects
   always_ff @(posedge clock) begin
      if (reset || redir) pipe_vld <= '0;
      else                pipe_vld <= MEM_LATENCY'({pipe_vld, mem_req});
   end

   // In-flight tags (epoch, pc) travel alongside the valid bits
   always_ff @(posedge clock) begin
      pipe_ep <= MEM_LATENCY'({pipe_ep, epoch});
      pipe_pc <= PC_W'({pipe_pc, fetch_pc});
   end

   // Prefetch FIFO pointers and occupancy; a redirect empties it
   always_ff @(posedge clock) begin
      if (reset || redir) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end
   end

   // Prefetch FIFO storage
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= pipe_pc[LAST];
         fifo_data[wr_ptr] <= mem_rdata;
      end
   end

   assign mem_addr  = fetch_pc;
   assign inst_pc   = inst_valid ? fifo_pc[rd_ptr]   : '0;
   assign inst_data = inst_valid ? fifo_data[rd_ptr] : '0;

   // The issue throttle must keep every push within FIFO capacity
   assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

`ifdef IFETCH_TRACE_EN
   // Simulation trace of accepted instructions and redirects
   always_ff @(posedge clock) begin
      if (!reset && inst_valid && inst_ready) $display("IF: pc=%h inst=%h", inst_pc, inst_data);
      if (!reset && redir) $display("IF: redirect %h", redirect_addr);
   end
`else
   // Trace disabled: no display logic in this build
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl (MEM_LATENCY=2, FIFO_DEPTH=4) with a
// fixed-latency memory model returning an address-derived word.
module tb_ifetch_ctrl;

   localparam logic [31:0] START = 32'h80020000;

   logic        clock = 1'b0;
   logic        reset, mem_req, inst_valid, inst_ready, redirect_valid, halt, misalign_err;
   logic [31:0] mem_addr, mem_rdata, inst_pc, inst_data, redirect_addr;
   logic [1:0]       mv = '0;
   logic [1:0][31:0] mq = '0;
   int n_vec = 0;
   int n_err = 0;

   ifetch_ctrl #(.START_ADDR(START), .MEM_LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_pc(inst_pc), .inst_data(inst_data), .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr), .halt(halt), .misalign_err(misalign_err)
   );

   initial forever #5 clock = ~clock;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5EEDC0DE;
   endfunction

   // Memory: word for a request appears exactly two cycles after it
   always @(posedge clock) begin
      mv <= {mv[0], mem_req};
      mq <= {mq[0], mem_addr};
   end
   assign mem_rdata = mv[1] ? word_of(mq[1]) : 32'h0;

   task automatic apply_reset(input logic ready);
      reset = 1'b1; inst_ready = ready; halt = 1'b0;
      redirect_valid = 1'b0; redirect_addr = '0;
      repeat (3) @(negedge clock);
      #1;
   endtask

   task automatic test_reset;
      apply_reset(1'b1);
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %h want 0", mem_req); end
      n_vec++; if (mem_addr !== START) begin n_err++; $display("FAIL reset_mem_addr got %h want %h", mem_addr, START); end
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %h want 0", inst_valid); end
      n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
      n_vec++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL reset_inst_data got %h want 0", inst_data); end
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %h want 0", misalign_err); end
      reset = 1'b0;
   endtask

   task automatic test_sequential;
      logic [31:0] e;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock); #1;
         e = START + 32'(4 * (k - 1));
         n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL seq_req[%0d] got %h want 1", k, mem_req); end
         n_vec++; if (mem_addr !== e) begin n_err++; $display("FAIL seq_addr[%0d] got %h want %h", k, mem_addr, e); end
         if (k < 4) begin
            n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL seq_fill_valid[%0d] got %h want 0", k, inst_valid); end
         end else begin
            e = START + 32'(4 * (k - 4));
            n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got %h want 1", k, inst_valid); end
            n_vec++; if (inst_pc !== e) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", k, inst_pc, e); end
            n_vec++; if (inst_data !== word_of(e)) begin n_err++; $display("FAIL seq_data[%0d] got %h want %h", k, inst_data, word_of(e)); end
         end
      end
   endtask

   task automatic test_stall;
      int nreq = 0;
      int got = 0;
      logic [31:0] e;
      apply_reset(1'b0);
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock); #1;
         if (mem_req) begin
            e = START + 32'(4 * nreq);
            n_vec++; if (mem_addr !== e) begin n_err++; $display("FAIL stall_addr got %h want %h", mem_addr, e); end
            nreq++;
         end
         if (k >= 4) begin
            n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %h want 1", k, inst_valid); end
            n_vec++; if (inst_pc !== START) begin n_err++; $display("FAIL stall_pc_hold[%0d] got %h want %h", k, inst_pc, START); end
            n_vec++; if (inst_data !== word_of(START)) begin n_err++; $display("FAIL stall_data_hold[%0d] got %h want %h", k, inst_data, word_of(START)); end
         end
      end
      n_vec++; if (nreq !== 4) begin n_err++; $display("FAIL stall_req_count got %0d want 4", nreq); end
      inst_ready = 1'b1; #1;
      e = START;
      for (int c = 0; c < 40; c++) begin
         if (inst_valid) begin
            n_vec++; if (inst_pc !== e) begin n_err++; $display("FAIL resume_pc got %h want %h", inst_pc, e); end
            n_vec++; if (inst_data !== word_of(e)) begin n_err++; $display("FAIL resume_data got %h want %h", inst_data, word_of(e)); end
            e += 32'd4; got++;
            if (got == 10) break;
         end
         @(negedge clock); #1;
      end
      n_vec++; if (got !== 10) begin n_err++; $display("FAIL resume_count got %0d want 10", got); end
   endtask

   task automatic test_redirect(input logic [31:0] target, input logic [31:0] aligned, input logic exp_mis);
      int got = 0;
      logic [31:0] e;
      redirect_valid = 1'b1; redirect_addr = target; #1;
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL redir_no_req got %h want 0", mem_req); end
      @(negedge clock); redirect_valid = 1'b0; #1;
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %h want 0", inst_valid); end
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL redir_req got %h want 1", mem_req); end
      n_vec++; if (mem_addr !== aligned) begin n_err++; $display("FAIL redir_addr got %h want %h", mem_addr, aligned); end
      n_vec++; if (misalign_err !== exp_mis) begin n_err++; $display("FAIL redir_misalign got %h want %h", misalign_err, exp_mis); end
      e = aligned;
      for (int c = 0; c < 20; c++) begin
         if (inst_valid) begin
            n_vec++; if (inst_pc !== e) begin n_err++; $display("FAIL redir_pc got %h want %h", inst_pc, e); end
            e += 32'd4; got++;
            if (got == 2) break;
         end
         @(negedge clock); #1;
      end
      n_vec++; if (got !== 2) begin n_err++; $display("FAIL redir_deliver_count got %0d want 2", got); end
   endtask

   task automatic test_halt;
      int c;
      halt = 1'b1; #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clock); #1; end
         n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL halt_req[%0d] got %h want 0", i, mem_req); end
      end
      @(negedge clock); redirect_valid = 1'b1; redirect_addr = 32'h80030000; #1;
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL halt_redir_req got %h want 0", mem_req); end
      @(negedge clock); redirect_valid = 1'b0; halt = 1'b0; #1;
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL halt_flush got %h want 0", inst_valid); end
      for (c = 0; c < 4; c++) begin
         if (mem_req) break;
         @(negedge clock); #1;
      end
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL halt_release_req got %h want 1", mem_req); end
      n_vec++; if (mem_addr !== 32'h80030000) begin n_err++; $display("FAIL halt_release_addr got %h want 80030000", mem_addr); end
      for (c = 0; c < 10; c++) begin
         if (inst_valid) break;
         @(negedge clock); #1;
      end
      n_vec++; if (inst_pc !== 32'h80030000) begin n_err++; $display("FAIL halt_first_pc got %h want 80030000", inst_pc); end
   endtask

   task automatic test_wrap_reset;
      logic [31:0] tbl [3] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
      int got = 0;
      redirect_valid = 1'b1; redirect_addr = 32'hFFFFFFF8;
      @(negedge clock); redirect_valid = 1'b0; #1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(negedge clock); #1; end
         n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req[%0d] got %h want 1", k, mem_req); end
         n_vec++; if (mem_addr !== tbl[k]) begin n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", k, mem_addr, tbl[k]); end
      end
      for (int c = 0; c < 20; c++) begin
         if (inst_valid) begin
            n_vec++; if (inst_pc !== tbl[got]) begin n_err++; $display("FAIL wrap_pc[%0d] got %h want %h", got, inst_pc, tbl[got]); end
            got++;
            if (got == 3) break;
         end
         @(negedge clock); #1;
      end
      n_vec++; if (got !== 3) begin n_err++; $display("FAIL wrap_deliver_count got %0d want 3", got); end
      n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_sticky got %h want 1", misalign_err); end
      reset = 1'b1;
      @(negedge clock); #1;
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL midrst_mem_req got %h want 0", mem_req); end
      n_vec++; if (mem_addr !== START) begin n_err++; $display("FAIL midrst_mem_addr got %h want %h", mem_addr, START); end
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_inst_valid got %h want 0", inst_valid); end
      n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL midrst_inst_pc got %h want 0", inst_pc); end
      n_vec++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL midrst_inst_data got %h want 0", inst_data); end
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL midrst_misalign got %h want 0", misalign_err); end
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock); #1;
         if (k == 1) begin
            n_vec++; if (mem_addr !== START || mem_req !== 1'b1) begin n_err++; $display("FAIL restart_addr got %h/%h want %h/1", mem_addr, mem_req, START); end
         end
         if (k < 4) begin
            n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL restart_stale_valid[%0d] got %h want 0", k, inst_valid); end
         end else begin
            n_vec++; if (inst_pc !== START) begin n_err++; $display("FAIL restart_pc got %h want %h", inst_pc, START); end
            n_vec++; if (inst_data !== word_of(START)) begin n_err++; $display("FAIL restart_data got %h want %h", inst_data, word_of(START)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect(32'h80020100, 32'h80020100, 1'b0);
      test_redirect(32'h80020102, 32'h80020100, 1'b1);
      test_halt();
      test_wrap_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
